// File: rtl/thor2023_dcinv_ctrl.sv
// Data-cache invalidation controller: queues snoop and software invalidate
// requests, issues them to the valid array one at a time, and backs off while
// line fills own the valid array, asking for a fill hold-off after repeated
// collisions.
module thor2023_dcinv_ctrl #(
    parameter int LINES    = 256,
    parameter int LOBIT    = 6,
    parameter int QDEPTH   = 4,
    parameter int MAXRETRY = 15,
    parameter int AW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          snp_valid,
    input  logic [AW-1:0] snp_adr,
    output logic          snp_ready,
    input  logic          req_valid,
    input  logic          req_all,
    input  logic [AW-1:0] req_adr,
    output logic          req_ready,
    input  logic          fill_wr,
    output logic          invce,
    output logic          invline,
    output logic          invall,
    output logic [AW-1:0] adr,
    output logic          done,
    output logic          fill_stall,
    output logic          idle
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int RW = (MAXRETRY > 0) ? $clog2(MAXRETRY + 1) : 1;

    // Reject geometries where the line index would not fit in the address.
    if (LOBIT + $clog2(LINES) > AW) begin : g_geom_check
        $error("line index bits exceed address width");
    end
    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_depth_check
        $error("QDEPTH must be a power of two and at least 2");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic          mem_all [QDEPTH];
    logic [AW-1:0] mem_adr [QDEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          cur_all_reg;
    logic [AW-1:0] cur_adr_reg;
    logic [RW-1:0] retry_reg;

    logic          full, empty;
    logic          enq_snp, enq_req, enq, enq_all;
    logic [AW-1:0] enq_adr;
    logic          issuing, retire, pop;

    assign full    = (count_reg == CW'(QDEPTH));
    assign empty   = (count_reg == '0);

    // Snoops win the single enqueue slot; nothing is accepted while in reset.
    assign snp_ready = !rst && !full;
    assign req_ready = !rst && !full && !snp_valid;
    assign enq_snp   = snp_valid && snp_ready;
    assign enq_req   = req_valid && req_ready;
    assign enq       = enq_snp || enq_req;
    assign enq_all   = enq_snp ? 1'b0 : req_all;
    assign enq_adr   = enq_snp ? snp_adr : req_adr;

    // A command retires in any issue cycle the fill path leaves free; the
    // head is pulled on retire (back-to-back) or whenever idle with work.
    assign issuing = (state_reg == S_ISSUE);
    assign retire  = issuing && !fill_wr;
    assign pop     = !empty && (!issuing || retire);

    // Next-state logic: leave IDLE once work is queued, leave ISSUE on a
    // retire that finds the queue drained.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (!empty) state_next = S_ISSUE;
            S_ISSUE: if (retire && empty) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Queue storage; contents are meaningless until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_all[wr_ptr_reg] <= enq_all;
            mem_adr[wr_ptr_reg] <= enq_adr;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at QDEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({enq, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Command being issued; held through fill collisions, kept while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_all_reg <= 1'b0;
            cur_adr_reg <= '0;
        end else if (pop) begin
            cur_all_reg <= mem_all[rd_ptr_reg];
            cur_adr_reg <= mem_adr[rd_ptr_reg];
        end
    end

    // Consecutive fill collisions on the current command, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       retry_reg <= '0;
        else if (retire)                               retry_reg <= '0;
        else if (issuing && retry_reg != RW'(MAXRETRY)) retry_reg <= retry_reg + 1'b1;
    end

    assign invce      = issuing;
    assign invline    = issuing && !cur_all_reg;
    assign invall     = issuing && cur_all_reg;
    assign adr        = cur_adr_reg;
    assign done       = retire;
    assign fill_stall = issuing && (retry_reg == RW'(MAXRETRY));
    assign idle       = !issuing && empty;

endmodule

// File: doc/thor2023_dcinv_ctrl.md
THOR2023_DCINV_CTRL -- requirements
Module: Thor2023_dcinv_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 256, number of cache lines per way.
REQ-002 SHALL have parameter LOBIT, default 6, lowest line-index bit of the address.
REQ-003 SHALL have parameter QDEPTH, default 4, invalidation queue depth (power of two, >=2).
REQ-004 SHALL have parameter MAXRETRY, default 15, fill collisions tolerated before fill_stall asserts.
REQ-005 SHALL have ports (name  direction  width  meaning):
  clk  in  1  the single clock, all state on rising edge.
  rst  in  1  asynchronous, active-high reset.
  snp_valid  in  1  snoop invalidate-line request.
  snp_adr  in  $bits(Address)  snoop physical address.
  snp_ready  out  1  snoop request accepted this cycle when high with snp_valid.
  req_valid  in  1  software cache-maintenance request.
  req_all  in  1  1 = invalidate all, 0 = invalidate line.
  req_adr  in  $bits(Address)  software physical address (ignored when req_all=1).
  req_ready  out  1  software request accepted when high with req_valid.
  fill_wr  in  1  valid-array line-fill write in this cycle (takes precedence over invce).
  invce  out  1  invalidate command to valid array.
  invline  out  1  line invalidate qualifier.
  invall  out  1  invalidate-all qualifier.
  adr  out  $bits(Address)  address for line invalidate.
  done  out  1  command retired this cycle.
  fill_stall  out  1  request to hold off fills.
  idle  out  1  queue empty and no command outstanding.

Function
REQ-006 SHALL hold a FIFO of QDEPTH entries {all, adr}; one enqueue per cycle max.
REQ-007 SHALL give snoop priority: snp_ready = !full; req_ready = !full & !snp_valid.
REQ-008 SHALL enqueue a snoop as {all=0, adr=snp_adr}, a software request as {req_all, req_adr}.
REQ-009 SHALL implement FSM states IDLE and ISSUE.
REQ-010 IDLE: if queue non-empty, pop head into output registers and go to ISSUE at that edge; else stay.
REQ-011 ISSUE: invce=1, invline=!entry.all, invall=entry.all, adr=entry.adr, all registered, stable.
REQ-012 Retire condition: ISSUE & !fill_wr; done SHALL be combinational = retire (1-cycle pulse).
REQ-013 On retire with queue non-empty SHALL pop next head and remain ISSUE (back-to-back, no bubble).
REQ-014 On retire with queue empty SHALL go to IDLE; invce/invline/invall SHALL be 0 in IDLE.
REQ-015 ISSUE & fill_wr (collision) SHALL hold all outputs unchanged and increment retry counter.
REQ-016 Retry counter SHALL clear on retire; saturate at MAXRETRY; fill_stall = ISSUE & (retry==MAXRETRY).
REQ-017 Enqueue and pop in same cycle with full queue SHALL be legal only when !full gates enqueue (no enqueue while full even if popping).
REQ-018 Enqueue into empty queue at edge E SHALL yield invce high in cycle after edge E+1 (latency 2 edges from acceptance).
REQ-019 idle SHALL = (state==IDLE) & queue empty.
REQ-020 FIFO pointers SHALL wrap modulo QDEPTH; count SHALL range 0..QDEPTH with full at QDEPTH.
REQ-021 adr SHALL retain last value in IDLE; value is don't-care when invce=0.

Reset
REQ-022 On rst high, asynchronously: state=IDLE, queue empty, retry=0, invce=invline=invall=0, adr=0, done=0, fill_stall=0.
REQ-023 snp_ready and req_ready SHALL be 0 while rst is high; idle SHALL be 1.
REQ-024 Reset mid-ISSUE SHALL discard the outstanding command and all queued entries without done.

Verification
REQ-025 Single line: req_valid=1, req_all=0, req_adr=0x1040 accepted edge E -> invce=1, invline=1, adr=0x1040 after E+1; done same cycle; idle=1 next cycle.
REQ-026 Collision: fill_wr=1 for 3 cycles during ISSUE -> outputs held 4 cycles, done only in 4th; retry returns to 0.
REQ-027 Starvation: fill_wr held 20 cycles, MAXRETRY=15 -> fill_stall rises at 16th ISSUE cycle, drops on retire.
REQ-028 Priority/full: snp_valid and req_valid both high, queue empty -> snoop accepted, req_ready=0; fill 4 entries -> snp_ready=0 until a pop.
REQ-029 Back-to-back: 3 queued entries (line 0x40, all, line 0x80), fill_wr=0 -> done high 3 consecutive cycles, invall=1 only in the second.
REQ-030 Async reset asserted mid-ISSUE with 2 entries queued -> invce=0 immediately, idle=1, no done; first post-reset request behaves as REQ-025.
